valid_rx_fifo: RTL and testbench

- Receive-side endpoint for the team's valid-only streaming interface, which has no backpressure.
- Captures every beat presented on i_valid/i_data, for example from the power pipeline's o_valid/o_data.
- Buffers beats in a small FIFO and re-presents them downstream on a valid/ready handshake.
- Beats that arrive when no slot is free are dropped, flagged by a sticky overflow bit and counted.

---
 rtl/valid_rx_fifo.sv | 90 +++++++++
 tb/tb_valid_rx_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/valid_rx_fifo.sv
// Receive endpoint for the valid-only stream: buffers every beat it can in a
// small FIFO, re-presents beats on valid/ready, and counts the beats it drops.
module valid_rx_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_valid,
  input  logic [DATA_WIDTH-1:0]      i_data,
  output logic                       o_valid,
  output logic [DATA_WIDTH-1:0]      o_data,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_overflow,
  output logic [CNT_WIDTH-1:0]       o_drop_cnt,
  input  logic                       i_clr_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]        FULL_LVL = CW'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DROP_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] DROP_MAX = '1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CW-1:0]         count;
  logic                  rd;
  logic                  wr;
  logic                  drop;

  // A read in the same cycle frees a slot, so a full FIFO still accepts.
  assign rd   = (count != '0) && i_ready;
  assign wr   = i_valid && ((count < FULL_LVL) || rd);
  assign drop = i_valid && !wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr) begin
        mem[wr_ptr] <= i_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr, rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // A drop in the same cycle as a clear restarts the tally at one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (i_clr_overflow) begin
        o_drop_cnt <= DROP_ONE;
      end else if (o_drop_cnt != DROP_MAX) begin
        o_drop_cnt <= o_drop_cnt + DROP_ONE;
      end
    end else if (i_clr_overflow) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end
  end

  assign o_valid = (count != '0);
  assign o_data  = mem[rd_ptr];
  assign o_full  = (count == FULL_LVL);
  assign o_count = count;

endmodule

// File: tb/tb_valid_rx_fifo.sv
// Self-checking bench for valid_rx_fifo: a queue scoreboard tracks accepted
// beats and a small occupancy/drop model supplies every expected value.
module tb_valid_rx_fifo;

  logic        clk;
  logic        reset_n;
  logic        i_valid;
  logic [63:0] i_data;
  logic        o_valid;
  logic [63:0] o_data;
  logic        i_ready;
  logic [2:0]  o_count;
  logic        o_full;
  logic        o_overflow;
  logic [15:0] o_drop_cnt;
  logic        i_clr_overflow;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] sb [$];
  int          m_count;
  logic        m_ovf;
  int          m_drops;

  valid_rx_fifo #(.DATA_WIDTH(64), .DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .o_valid        (o_valid),
    .o_data         (o_data),
    .i_ready        (i_ready),
    .o_count        (o_count),
    .o_full         (o_full),
    .o_overflow     (o_overflow),
    .o_drop_cnt     (o_drop_cnt),
    .i_clr_overflow (i_clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  // One clock: checks head data before the edge, then state after it.
  task automatic cycle();
    logic rd_m, wr_m, drop_m;
    rd_m   = (m_count != 0) && i_ready;
    wr_m   = i_valid && ((m_count < 4) || rd_m);
    drop_m = i_valid && !wr_m;
    if (m_count != 0) begin
      check("head_data", o_data, sb[0]);
    end
    if (rd_m) void'(sb.pop_front());
    if (wr_m) sb.push_back(i_data);
    if (wr_m && !rd_m) m_count++;
    if (rd_m && !wr_m) m_count--;
    if (drop_m) begin
      m_ovf   = 1'b1;
      m_drops = i_clr_overflow ? 1 : ((m_drops < 65535) ? m_drops + 1 : m_drops);
    end else if (i_clr_overflow) begin
      m_ovf   = 1'b0;
      m_drops = 0;
    end
    @(posedge clk);
    #1;
    check("count",    64'(o_count),    64'(m_count));
    check("valid",    64'(o_valid),    64'(m_count != 0));
    check("full",     64'(o_full),     64'(m_count == 4));
    check("overflow", 64'(o_overflow), 64'(m_ovf));
    check("drop_cnt", 64'(o_drop_cnt), 64'(m_drops));
  endtask

  task automatic apply_stimulus(input logic v, input logic [63:0] d, input logic r, input logic c);
    i_valid        = v;
    i_data         = d;
    i_ready        = r;
    i_clr_overflow = c;
    cycle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},    64'(o_valid),    64'(0));
    check({tag, "_count"},    64'(o_count),    64'(0));
    check({tag, "_full"},     64'(o_full),     64'(0));
    check({tag, "_overflow"}, 64'(o_overflow), 64'(0));
    check({tag, "_drop_cnt"}, 64'(o_drop_cnt), 64'(0));
    check({tag, "_data"},     o_data,          64'(0));
  endtask

  initial begin
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_data = '0;
    i_ready = 1'b0;
    i_clr_overflow = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_all_zero("reset");

    // Idle with ready high: nothing appears
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b0);

    // Three beats buffered, then drained in order
    apply_stimulus(1'b1, 64'h1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 64'h100, 1'b0, 1'b0);
    apply_stimulus(1'b1, 64'h10000, 1'b0, 1'b0);
    check("three_count", 64'(o_count), 64'(3));
    check("three_head", o_data, 64'h1);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check("drained_valid", 64'(o_valid), 64'(0));
    check("drained_count", 64'(o_count), 64'(0));

    // Six beats into a four-deep FIFO: two dropped
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 64'hD000 + 64'(i), 1'b0, 1'b0);
      if (i == 3) check("full_after_4", 64'(o_full), 64'(1));
    end
    check("ovf_after_6", 64'(o_overflow), 64'(1));
    check("drops_after_6", 64'(o_drop_cnt), 64'(2));
    for (int i = 0; i < 4; i++) begin
      check("drain_d", o_data, 64'hD000 + 64'(i));
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    end

    // Full with simultaneous read and write: no drops, pointers wrap
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 64'hE000 + 64'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 64'hF000 + 64'(i), 1'b1, 1'b0);
    check("pass_through_count", 64'(o_count), 64'(4));
    check("pass_through_drops", 64'(o_drop_cnt), 64'(2));
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b0);

    // Clear, then clear coinciding with a drop
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    check("clr_ovf", 64'(o_overflow), 64'(0));
    check("clr_cnt", 64'(o_drop_cnt), 64'(0));
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 64'hA000 + 64'(i), 1'b0, 1'b0);
    apply_stimulus(1'b1, 64'hBAD0, 1'b0, 1'b1);
    check("clr_drop_ovf", 64'(o_overflow), 64'(1));
    check("clr_drop_cnt", 64'(o_drop_cnt), 64'(1));
    apply_stimulus(1'b1, 64'hBAD1, 1'b0, 1'b0);
    check("drop_after_clr_cnt", 64'(o_drop_cnt), 64'(2));
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-burst
    apply_stimulus(1'b1, 64'hC000, 1'b0, 1'b0);
    apply_stimulus(1'b1, 64'hC001, 1'b0, 1'b0);
    check("pre_reset_count", 64'(o_count), 64'(2));
    i_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check("post_reset_valid", 64'(o_valid), 64'(0));
    apply_stimulus(1'b1, 64'h5A5A, 1'b0, 1'b0);
    check("new_beat_valid", 64'(o_valid), 64'(1));
    check("new_beat_data", o_data, 64'h5A5A);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
